// File: rtl/irq_pkg.sv
// Shared constants for the four-channel interrupt request latch.
// Channel count, index width, enable reset value and mode encodings.
package irq_pkg;

    localparam int N_CH = 4;
    localparam int ID_W = 2;

    localparam logic [N_CH-1:0] EN_RST = 4'hF;

    localparam int MODE_EDGE  = 0;
    localparam int MODE_LEVEL = 1;

    function automatic logic [N_CH-1:0] id_onehot(input logic [ID_W-1:0] id);
        return N_CH'(1) << id;
    endfunction

endpackage

// File: rtl/irq_request_latch_bit_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous request line.
// Chain depth is SYNC_STAGES; synchronous active-low reset.
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_request_latch.sv
// Four-channel request capture: synchronise, edge-detect, hold pending
// until acked through the downstream priority encoder feedback.
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LEVEL_MODE  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] irq_in,
    input  logic            en_wr,
    input  logic [N_CH-1:0] en_data,
    input  logic            ack,
    input  logic [ID_W-1:0] enc_y,
    input  logic            enc_valid,
    input  logic            ovr_clr,
    output logic [N_CH-1:0] pend_out,
    output logic            irq_out,
    output logic [N_CH-1:0] overrun
);

    logic [N_CH-1:0] sync_last;
    logic [N_CH-1:0] prev_q, prev_d;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] overrun_q, overrun_d;
    logic [N_CH-1:0] en_q, en_d;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] clr;

    for (genvar i = 0; i < N_CH; i++) begin : g_sync
        bit_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (irq_in[i]),
            .q    (sync_last[i])
        );
    end

    always_comb begin
        rise   = sync_last & ~prev_q;
        prev_d = sync_last;
        en_d   = en_wr ? en_data : en_q;
        clr    = '0;
        // Only a channel visible to the encoder may be acknowledged.
        if (ack && enc_valid && en_q[enc_y]) begin
            clr = id_onehot(enc_y);
        end
        if (LEVEL_MODE == MODE_LEVEL) begin
            pending_d = sync_last;
            overrun_d = '0;
        end else begin
            pending_d = (pending_q & ~clr) | rise;
            overrun_d = (ovr_clr ? '0 : overrun_q)
                      | (rise & pending_q & ~clr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            en_q      <= EN_RST;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            en_q      <= en_d;
        end
    end

    assign pend_out = pending_q & en_q;
    assign irq_out  = |pend_out;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Randomised and directed bench for irq_request_latch (edge mode, 2 stages,
// and level mode, 3 stages) against a sample-history reference model.
module tb_irq_request_latch;

    localparam int SS[2] = '{2, 3};
    localparam int LM[2] = '{0, 1};
    localparam int HMAX  = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] irq_in = 4'h0;
    logic       en_wr = 1'b0;
    logic [3:0] en_data = 4'h0;
    logic       ack = 1'b0;
    logic [1:0] enc_y;
    logic       enc_valid;
    logic       ovr_clr = 1'b0;
    logic       enc_auto = 1'b1;
    logic [1:0] r_y = 2'd0;
    logic       r_v = 1'b0;

    logic [3:0] pend_o[2];
    logic       irq_o[2];
    logic [3:0] ovr_o[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_request_latch #(.SYNC_STAGES(2), .LEVEL_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .en_wr(en_wr),
        .en_data(en_data), .ack(ack), .enc_y(enc_y), .enc_valid(enc_valid),
        .ovr_clr(ovr_clr), .pend_out(pend_o[0]), .irq_out(irq_o[0]),
        .overrun(ovr_o[0])
    );

    irq_request_latch #(.SYNC_STAGES(3), .LEVEL_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .en_wr(en_wr),
        .en_data(en_data), .ack(ack), .enc_y(enc_y), .enc_valid(enc_valid),
        .ovr_clr(ovr_clr), .pend_out(pend_o[1]), .irq_out(irq_o[1]),
        .overrun(ovr_o[1])
    );

    // Behaves like the downstream 4:2 priority encoder on instance 0.
    always_comb begin
        enc_y     = r_y;
        enc_valid = r_v;
        if (enc_auto) begin
            enc_valid = |pend_o[0];
            enc_y     = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (pend_o[0][i]) enc_y = 2'(i);
            end
        end
    end

    // Reference: hist[k] is irq_in as seen at edge k (zero at reset edges).
    logic [3:0] hist[HMAX];
    int         k = 0;
    int         last_rst = 0;
    bit         started = 1'b0;
    logic [3:0] m_pend[2];
    logic [3:0] m_ovr[2];
    logic [3:0] m_en;

    function automatic logic [3:0] get(input int idx);
        if (idx <= last_rst || idx < 0) return 4'h0;
        return hist[idx];
    endfunction

    always @(posedge clk) begin
        logic [3:0] s, p, rise, clr, nov;
        k = k + 1;
        if (k >= HMAX) k = HMAX - 1;
        started = 1'b1;
        if (!rst_n) begin
            hist[k]  = 4'h0;
            last_rst = k;
            for (int j = 0; j < 2; j++) begin
                m_pend[j] = 4'h0;
                m_ovr[j]  = 4'h0;
            end
            m_en = 4'hF;
        end else begin
            hist[k] = irq_in;
            for (int j = 0; j < 2; j++) begin
                s    = get(k - SS[j]);
                p    = get(k - SS[j] - 1);
                rise = s & ~p;
                if (LM[j] == 1) begin
                    m_pend[j] = s;
                    m_ovr[j]  = 4'h0;
                end else begin
                    clr = 4'h0;
                    if (ack && enc_valid && m_en[enc_y]) clr[enc_y] = 1'b1;
                    nov       = rise & m_pend[j] & ~clr;
                    m_pend[j] = (m_pend[j] & ~clr) | rise;
                    m_ovr[j]  = (ovr_clr ? 4'h0 : m_ovr[j]) | nov;
                end
            end
            if (en_wr) m_en = en_data;
        end
    end

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("pend_out[%0d]", j), pend_o[j], m_pend[j] & m_en);
                chk($sformatf("irq_out[%0d]", j), {3'b0, irq_o[j]},
                    {3'b0, |(m_pend[j] & m_en)});
                chk($sformatf("overrun[%0d]", j), ovr_o[j], m_ovr[j]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Holds mask for 2 cycles, releases; returns just after edge E3.
    task automatic pulse(input logic [3:0] m);
        irq_in = m;
        step();
        step();
        irq_in = 4'h0;
        step();
    endtask

    task automatic drain();
        ack = 1'b1;
        idle(5);
        ack = 1'b0;
        idle(4);
    endtask

    initial begin
        rst_n  = 1'b0;
        irq_in = 4'hF;
        step();
        chk("rst_pend", pend_o[0], 4'h0);
        chk("rst_ovr", ovr_o[0], 4'h0);
        step();
        chk("rst_irq", {3'b0, irq_o[0]}, 4'h0);
        rst_n = 1'b1;
        step();
        chk("rel_pend", pend_o[0], 4'h0);
        step();
        chk("rel_pend2", pend_o[0], 4'h0);
        step();
        chk("rel_pend_f", pend_o[0], 4'hF);
        chk("rel_model_f", m_pend[0], 4'hF);
        irq_in = 4'h0;
        drain();

        pulse(4'b0100);
        chk("lat_pend", pend_o[0], 4'b0100);
        chk("lat_irq", {3'b0, irq_o[0]}, 4'h1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_pend", pend_o[0], 4'h0);
        chk("ack_irq", {3'b0, irq_o[0]}, 4'h0);
        idle(3);

        pulse(4'b1011);
        chk("drain0", pend_o[0], 4'b1011);
        ack = 1'b1;
        step();
        chk("drain1", pend_o[0], 4'b0011);
        step();
        chk("drain2", pend_o[0], 4'b0001);
        step();
        chk("drain3", pend_o[0], 4'b0000);
        chk("drain_model", m_pend[0], 4'b0000);
        ack = 1'b0;
        idle(4);

        pulse(4'b0001);
        idle(3);
        irq_in = 4'b0001;
        step();
        step();
        ack = 1'b1;
        step();
        ack    = 1'b0;
        irq_in = 4'h0;
        chk("setwins_pend", pend_o[0], 4'b0001);
        chk("setwins_ovr", ovr_o[0], 4'b0000);
        drain();

        pulse(4'b0010);
        idle(3);
        pulse(4'b0010);
        chk("ovr_set", ovr_o[0], 4'b0010);
        idle(3);
        irq_in = 4'b0010;
        step();
        step();
        ovr_clr = 1'b1;
        irq_in  = 4'h0;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clr_race", ovr_o[0], 4'b0010);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clr", ovr_o[0], 4'b0000);
        drain();

        en_wr   = 1'b1;
        en_data = 4'b0111;
        step();
        en_wr = 1'b0;
        pulse(4'b1000);
        chk("mask_pend", pend_o[0], 4'h0);
        chk("mask_irq", {3'b0, irq_o[0]}, 4'h0);
        en_wr   = 1'b1;
        en_data = 4'hF;
        step();
        en_wr = 1'b0;
        chk("unmask_pend", pend_o[0], 4'b1000);
        drain();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom_range(0, 15));
            ack      = 1'($urandom_range(0, 1));
            enc_auto = ($urandom_range(0, 3) != 0);
            r_y      = 2'($urandom_range(0, 3));
            r_v      = 1'($urandom_range(0, 1));
            en_wr    = ($urandom_range(0, 15) == 0);
            en_data  = 4'($urandom_range(0, 15));
            ovr_clr  = ($urandom_range(0, 15) == 0);
            rst_n    = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_request_latch.md
# irq_request_latch

Four-channel request capture stage that sits directly upstream of the 4:2 priority encoder. It synchronises raw request lines, detects rising edges, and holds each event in a pending register until a consumer acknowledges it. It drives the encoder's `D` input with the masked pending vector and takes the encoder's `Y`/`valid` back to clear the serviced channel.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchroniser per channel. Legal values are 2 or 3.
- `LEVEL_MODE`, default 0: 0 captures rising edges into sticky pending bits. 1 makes pending follow the synchronised level.

Ports:
- `clk`  in  1  single clock for all state.
- `rst_n`  in  1  reset, synchronous, active-low.
- `irq_in`  in  4  raw asynchronous request lines. Bit 3 is highest priority downstream.
- `en_wr`  in  1  write strobe for the channel-enable register.
- `en_data`  in  4  new enable value, taken when `en_wr`=1.
- `ack`  in  1  consumer has serviced the request currently encoded.
- `enc_y`  in  2  index from the downstream encoder `Y`.
- `enc_valid`  in  1  downstream encoder `valid`.
- `ovr_clr`  in  1  clears all overrun flags.
- `pend_out`  out  4  pending & enable. Drives encoder `D`.
- `irq_out`  out  1  OR of `pend_out`.
- `overrun`  out  4  sticky per-channel overrun flags.

## Operation
- Each channel passes through a `SYNC_STAGES` flop chain, then one "prev" flop.
- The rise condition is `sync_last & ~prev`.
- Edge mode (`LEVEL_MODE`=0):
  - A rise sets `pending[i]`.
  - `ack & enc_valid` clears `pending[enc_y]`.
  - If a rise and a clear hit the same bit in the same cycle, the set wins. No event is lost.
  - `ack` while `enc_valid`=0 is ignored.
- Overrun:
  - `overrun[i]` sets on a rise while `pending[i]`=1, unless that bit is also being cleared by ack in that cycle.
  - `ovr_clr` zeroes all overrun bits.
  - If a set and `ovr_clr` coincide, the set wins.
- Level mode (`LEVEL_MODE`=1):
  - `pending <= sync_last` every cycle.
  - `ack` has no effect.
  - `overrun` stays 0.
- Enable register `en`:
  - Written on `en_wr`.
  - Masking affects only `pend_out`. A disabled channel still latches events and overruns, and presents them once re-enabled.
  - Ack only clears a bit visible on `pend_out`. With an `enc_y` whose bit is disabled, the ack is ignored.
- Outputs:
  - `pend_out = pending & en`.
  - `irq_out = |pend_out`.
  - Both are pure functions of registers, so they are glitch-free.
- Reset (`rst_n`=0 at an edge) clears everything, mid-operation included, in that cycle:
  - sync chains, prev, pending and overrun to 0.
  - `en` to 4'b1111.
  - Outputs: `pend_out`=0, `irq_out`=0, `overrun`=0.

## Timing
- Latency, with `irq_in[i]` rising before edge E1:
  - Sync output goes high after E`SYNC_STAGES`.
  - `pending[i]`, `pend_out[i]` and `irq_out` go high after E(`SYNC_STAGES`+1). This is 3 edges at the default.
- A pulse narrower than one clock period is not guaranteed to be captured. A pulse held for 2 or more cycles is always captured exactly once.
- A new rise requires `irq_in` to be low for at least one synchronised cycle in between.
- Ack handshake:
  - `ack` is sampled at an edge together with `enc_y`/`enc_valid`.
  - The bit clears after that edge.
  - The encoder presents the next-priority index combinationally in the following cycle.
  - Holding `ack` high clears one bit per cycle.
- `en_wr` takes effect on `pend_out` after the writing edge.
- `ovr_clr` clears after its edge.

## Structure
- Shared package `irq_pkg`:
  - `N_CH`=4 and `ID_W`=2.
  - Reset value of `en` (4'hF).
  - Localparams for `LEVEL_MODE` encodings.
- One sub-module: `bit_sync`, a single-bit `SYNC_STAGES`-deep synchroniser with synchronous active-low reset. It is instantiated 4 times.
- Edge detect, pending, enable and overrun logic live in the top module.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles with `irq_in`=4'hF. While reset is asserted and after its release edge, `pend_out`=0, `overrun`=0 and `irq_out`=0. After release, `pend_out`=4'hF appears 3 edges later.
- Edge latency and clear:
  - `irq_in`=4'b0100 held 2 cycles gives `pend_out`=4'b0100 after E3.
  - Then `ack`=1, `enc_y`=2'b10, `enc_valid`=1 for one edge gives `pend_out`=0 and `irq_out`=0 in the next cycle.
- Priority drain: pending 4'b1011, then `ack` held high with encoder feedback. `pend_out` must step 1011 -> 0011 -> 0001 -> 0000 over 3 edges.
- Simultaneous set and clear: a rise on ch0 lands on the same edge as an ack of ch0. `pend_out[0]` stays 1 and `overrun[0]` stays 0.
- Overrun: ch1 pending, then a second rise on ch1 gives `overrun`=4'b0010. A later `ovr_clr` coinciding with a further rise leaves `overrun`=4'b0010; `ovr_clr` alone clears it.
- Masking: write `en`=4'b0111, then a rise on ch3 gives `pend_out`=0 and `irq_out`=0. Write `en`=4'hF and `pend_out`=4'b1000 appears on the next cycle.
